mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (data load/store).
- Serialises requests with one outstanding transaction, round-robin on ties, and a req/ready/rvalid memory handshake.
- Generates the stall_if / stall_mem signals that freeze the pipeline alongside the load-use and control-hazard stalls.
- Sits between the pipeline stages and the memory model/bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 bits)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held until if_valid or dropped on flush
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction (registered)
if_valid  out  1  one-cycle fetch completion pulse
dmem_req  in  1  data request; held until dmem_valid
dmem_we  in  1  1=store, 0=load
dmem_addr  in  ADDR_W  data address
dmem_wdata  in  DATA_W  store data
dmem_be  in  DATA_W/8  store byte enables
dmem_rdata  out  DATA_W  load data (registered)
dmem_valid  out  1  one-cycle data completion pulse
mem_req  out  1  memory request (registered)
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_ready  in  1  memory accepts the request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
stall_if  out  1  IF stage must hold
stall_mem  out  1  MEM stage (and everything upstream) must hold

Behaviour:
- States: IDLE, ISSUE, RESP. Register owner (0=fetch, 1=data) and last_grant.
- Reset: state=IDLE, last_grant=fetch, and every registered output = 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, if_valid, dmem_rdata, dmem_valid).
- IDLE: eligible requester = req high AND its valid not asserted this cycle (this prevents re-issuing a just-completed request).
  - Only one eligible: grant it.
  - Both eligible: grant the one not equal to last_grant, so data wins the first tie after reset.
  - On grant: latch addr/we/wdata/be (fetch: we=0, be=all ones) onto mem_* outputs, set mem_req=1, update last_grant, go to ISSUE.
- ISSUE: hold mem_req and all fields stable until mem_ready.
  - On mem_ready with a store: drop mem_req, pulse dmem_valid next cycle, go to IDLE.
  - On mem_ready with a load/fetch: drop mem_req, go to RESP.
- RESP: wait for mem_rvalid. Then capture mem_rdata into if_rdata or dmem_rdata (by owner), pulse the owner's valid next cycle, go to IDLE.
  - mem_rvalid outside RESP is ignored.
- Minimum read latency: request seen cycle 0 -> mem_req cycle 1 -> (ready in cycle 1) RESP cycle 2 -> (rvalid in cycle 2) valid cycle 3. Next issue no earlier than cycle 3.
- Flush: if the owner's req is low at completion, the transaction still finishes on the bus (stores still written), but the valid pulse is suppressed and rdata is not updated.
- stall_if = if_req & ~if_valid; stall_mem = dmem_req & ~dmem_valid. Both combinational.
- A requester that loses arbitration stays stalled. With both requesting continuously, grants alternate data, fetch, data, ...
- rdata outputs hold their last captured value between transactions.
- Reset mid-transaction: immediate return to IDLE, mem_req drops asynchronously, and the in-flight response is discarded.

Decomposition:
- Shared package mem_pkg: state enum (IDLE/ISSUE/RESP), owner constants OWN_IF/OWN_DATA, ADDR_W/DATA_W defaults.
- Optional sub-module rr_arb2 (2-way round-robin pick from two req bits plus last_grant).
- Everything else stays inline.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; mem_ready same cycle; rvalid with 0x00500093 one cycle later -> if_valid pulses exactly cycle 3 with if_rdata=0x00500093; stall_if=1 in cycles 0-2, 0 in cycle 3.
- Simultaneous after reset: if_req and dmem_req (load 0x2000) rise together, memory always ready, rvalid after 1 cycle -> data granted first (mem_addr=0x2000), then fetch; continuous requests alternate data/fetch.
- Store: dmem_we=1, addr=0x3000, wdata=0xDEADBEEF, be=0xF; mem_ready delayed 4 cycles -> mem_* held stable 4 cycles, dmem_valid one cycle after acceptance, no RESP state entered.
- Fetch flush: drop if_req in RESP before rvalid -> if_valid stays 0, if_rdata unchanged, FSM returns to IDLE, next request issues normally.
- Reset mid-ISSUE: assert rst while mem_req=1 -> mem_req, valids and rdata outputs 0 immediately; after release the first request issues cleanly.
- No duplicate issue: hold if_req high across completion with the same address -> exactly one mem_req per if_valid pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Owner encoding doubles as the round-robin last_grant value.
package mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OWN_IF   = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is chosen.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,          // bit 0 = fetch, bit 1 = data
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_owner_o
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_valid_o = |req_i;
    grant_owner_o = OWN_IF;
    case (req_i)
      2'b01:   grant_owner_o = OWN_IF;
      2'b10:   grant_owner_o = OWN_DATA;
      2'b11:   grant_owner_o = ~last_grant_i;
      default: grant_owner_o = OWN_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction
// in flight, with registered bus outputs and one-cycle completion pulses.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                dmem_req,
  input  logic                dmem_we,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_be,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  state_t              state_q;
  logic                owner_q, last_grant_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rdata_q, dmem_rdata_q;
  logic [DATA_W/8-1:0] mem_be_q;
  logic                if_valid_q, dmem_valid_q;
  logic                if_elig, dmem_elig, grant_valid, grant_owner;

  // A requester whose completion pulse is out this cycle is still holding the
  // same request; it must not be issued a second time.
  assign if_elig   = if_req   & ~if_valid_q;
  assign dmem_elig = dmem_req & ~dmem_valid_q;

  rr_arb2 u_arb (
    .req_i         ({dmem_elig, if_elig}),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      dmem_rdata_q <= '0;
      dmem_valid_q <= 1'b0;
    end else begin
      if_valid_q   <= 1'b0;
      dmem_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q      <= grant_owner;
            last_grant_q <= grant_owner;
            mem_req_q    <= 1'b1;
            state_q      <= ISSUE;
            if (grant_owner == OWN_DATA) begin
              mem_we_q    <= dmem_we;
              mem_addr_q  <= dmem_addr;
              mem_wdata_q <= dmem_wdata;
              mem_be_q    <= dmem_be;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= '1;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              // Only data stores set mem_we; no read response follows.
              dmem_valid_q <= dmem_req;
              state_q      <= IDLE;
            end else begin
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            state_q <= IDLE;
            // A dropped request (flush) completes on the bus but is not reported.
            if (owner_q == OWN_DATA) begin
              if (dmem_req) begin
                dmem_rdata_q <= mem_rdata;
                dmem_valid_q <= 1'b1;
              end
            end else if (if_req) begin
              if_rdata_q <= mem_rdata;
              if_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign if_rdata   = if_rdata_q;
  assign if_valid   = if_valid_q;
  assign dmem_rdata = dmem_rdata_q;
  assign dmem_valid = dmem_valid_q;
  assign stall_if   = if_req & ~if_valid_q;
  assign stall_mem  = dmem_req & ~dmem_valid_q;

endmodule
